// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl
//   Sequences an external pipelined AES-128 key expander and keeps the
//   resulting round keys in a local bank. The bank is read by round index.
//   A new key is latched, launched to the expander with a single pulse, and
//   the bank is filled when the expander's last-stage valid arrives.
//
// Ports
//   clk, reset              clock, asynchronous active-low reset
//   key_in/key_valid        key load request; key_ready says it is accepted
//   keys_valid              bank holds a complete schedule
//   rk_req/rk_idx           round-key read request (index 0..NUMS_OF_ROUND)
//   rk_out/rk_ack/rk_err    registered read response, 1-cycle latency
//   exp_key/exp_valid_in    key and launch pulse to the expander
//   exp_key_expan           expander round keys, round 1 in the LSBs
//   exp_valid_out           expander per-stage valids (only the last is used)
//   sched_err               watchdog expired
//
// Optional feature: define KEY_SCHED_TIMEOUT_EN to enable a watchdog on the
// WAIT state. Without it WAIT waits indefinitely and sched_err is tied 0.
module aes_key_sched_ctrl #(
    parameter int KEY_LEN       = 128,
    parameter int NUMS_OF_ROUND = 10,
    parameter int TIMEOUT_CYC   = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [KEY_LEN-1:0]               key_in,
    input  logic                             key_valid,
    output logic                             key_ready,
    output logic                             keys_valid,
    input  logic                             rk_req,
    input  logic [3:0]                       rk_idx,
    output logic [KEY_LEN-1:0]               rk_out,
    output logic                             rk_ack,
    output logic                             rk_err,
    output logic [KEY_LEN-1:0]               exp_key,
    output logic                             exp_valid_in,
    input  logic [NUMS_OF_ROUND*KEY_LEN-1:0] exp_key_expan,
    input  logic [NUMS_OF_ROUND-1:0]         exp_valid_out,
    output logic                             sched_err
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, READY} state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   last_vld;
    logic   timeout;
    logic   idx_ok;

    logic [KEY_LEN-1:0] bank [0:NUMS_OF_ROUND];

    // Only the final pipeline stage matters; earlier stage valids are unused.
    logic unused_stage_vld;
    assign unused_stage_vld = ^exp_valid_out[NUMS_OF_ROUND-2:0];

    assign last_vld = exp_valid_out[NUMS_OF_ROUND-1];
    assign accept   = key_valid & key_ready;
    assign idx_ok   = (rk_idx <= 4'(NUMS_OF_ROUND));

`ifdef KEY_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    // wait_cnt = cycles elapsed since the launch cycle.
    logic [CW-1:0] wait_cnt;
    logic          sched_err_q;

    assign timeout   = (state == WAIT) && !last_vld && (wait_cnt == CW'(TIMEOUT_CYC - 1));
    assign sched_err = sched_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt    <= '0;
            sched_err_q <= 1'b0;
        end else begin
            if (state == LAUNCH)
                wait_cnt <= CW'(1);
            else if (state == WAIT)
                wait_cnt <= wait_cnt + CW'(1);
            // Sticky until the next key is accepted.
            if (accept)
                sched_err_q <= 1'b0;
            else if (timeout)
                sched_err_q <= 1'b1;
        end
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout   = 1'b0;
    assign sched_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        key_ready    = 1'b0;
        keys_valid   = 1'b0;
        exp_valid_in = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                exp_valid_in = 1'b1;
                state_nxt    = WAIT;
            end
            WAIT: begin
                if (last_vld)     state_nxt = READY;
                else if (timeout) state_nxt = IDLE;
            end
            READY: begin
                key_ready  = 1'b1;
                keys_valid = 1'b1;
                if (key_valid) state_nxt = LAUNCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Key latch and bank fill. A last-stage valid outside WAIT is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_key <= '0;
            for (int r = 0; r <= NUMS_OF_ROUND; r++) bank[r] <= '0;
        end else begin
            if (accept) begin
                exp_key <= key_in;
                bank[0] <= key_in;
            end
            if (state == WAIT && last_vld) begin
                for (int r = 1; r <= NUMS_OF_ROUND; r++)
                    bank[r] <= exp_key_expan[r*KEY_LEN-1 -: KEY_LEN];
            end
        end
    end

    // Read port. keys_valid is the current-cycle value, so a read issued in
    // the same cycle as a new-key accept still returns the old schedule.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rk_out <= '0;
            rk_ack <= 1'b0;
            rk_err <= 1'b0;
        end else begin
            rk_ack <= rk_req;
            if (rk_req) begin
                if (keys_valid && idx_ok) begin
                    rk_out <= bank[rk_idx];
                    rk_err <= 1'b0;
                end else begin
                    rk_out <= '0;
                    rk_err <= 1'b1;
                end
            end else begin
                rk_err <= 1'b0;
            end
        end
    end

endmodule
